// File: rtl/rotator_pkg.sv
// rotator_pkg -- shared definitions for the rotator arbiter slice.
//   DIR_LEFT / DIR_RIGHT : encoding of the per-request rotate direction bit
//   arb_state_t          : response-slot state (IDLE = empty, RESP = result held)
//   STATS_W              : width of the optional completed-operation counter
package rotator_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/rotator.sv
// rotator -- combinational circular rotate of one WIDTH-bit word.
// Ports:
//   data_i   [WIDTH-1:0] operand
//   amount_i [AMT_W-1:0] rotate distance (0 leaves the word unchanged)
//   dir_i                DIR_LEFT or DIR_RIGHT
//   result_o [WIDTH-1:0] rotated word
module rotator
  import rotator_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] result_o
);

  // Shifting a doubled copy of the word turns a plain shift into a rotate:
  // bits pushed out of one half re-enter from the other, so nothing is lost.
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] shl;
  logic [2*WIDTH-1:0] shr;

  assign dbl = {data_i, data_i};
  assign shl = dbl << amount_i;
  assign shr = dbl >> amount_i;

  assign result_o = (dir_i == DIR_RIGHT) ? shr[WIDTH-1:0] : shl[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin grant selection.
// Ports:
//   req_i       [NUM_REQ-1:0] request vector
//   ptr_i       [ID_W-1:0]    highest-priority index (held by the parent)
//   en_i                      grants allowed this cycle
//   gnt_o       [NUM_REQ-1:0] one-hot grant (all zero when disabled or idle)
//   gnt_idx_o   [ID_W-1:0]    encoded index of the winner
//   gnt_valid_o               a grant is issued
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        idx_sum;

  // Rotate the request vector so the pointer position sits at bit 0; the
  // lowest set bit of req_rot is then the first requester at or above ptr_i.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = ID_W'(k);
      end
    end
  end

  // Map the offset back to an absolute index, wrapping at NUM_REQ.
  always_comb begin
    idx_sum = {1'b0, ptr_i} + {1'b0, offset};
    if (idx_sum >= (ID_W + 1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (ID_W + 1)'(NUM_REQ);
    end
  end

  assign gnt_idx_o   = idx_sum[ID_W-1:0];
  assign gnt_valid_o = en_i && found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
    assign gnt_o[gi] = gnt_valid_o && (gnt_idx_o == ID_W'(gi));
  end

endmodule

// File: rtl/rotator_arbiter.sv
// rotator_arbiter -- shares one rotator among NUM_REQ valid/ready requesters
// with round-robin arbitration and a single registered, ID-tagged response.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   req_valid/req_ready       per-requester handshake (req_ready one-hot or zero)
//   req_data/req_amount/
//   req_dir                   packed per-requester operands, slot i at [i*W +: W]
//   resp_valid/resp_ready     response handshake
//   resp_data, resp_id        rotated result and index of its requester
// Build option ROTATOR_ARB_STATS_EN adds op_count (saturating count of
// response handshakes) and stats_clr (synchronous clear of that count).
module rotator_arbiter
  import rotator_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int AMT_W   = $clog2(WIDTH),
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0] req_amount,
  input  logic [NUM_REQ-1:0]       req_dir,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id
`ifdef ROTATOR_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]       op_count,
  input  logic                     stats_clr
`endif
);

  arb_state_t       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic [ID_W-1:0]  resp_id_q;

  logic             slot_free;
  logic             arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             accept;

  logic [WIDTH-1:0] data_arr [NUM_REQ];
  logic [AMT_W-1:0] amt_arr  [NUM_REQ];
  logic [WIDTH-1:0] rot_result;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    assign amt_arr[gi]  = req_amount[gi*AMT_W +: AMT_W];
  end

  // The slot is free when empty or when the held result leaves this cycle,
  // which lets a new result replace it back-to-back.
  assign slot_free = (state_q == IDLE) || (resp_valid_q && resp_ready);
  assign arb_en    = slot_free && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .en_i        (arb_en),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (accept)
  );

  assign req_ready = gnt;

  rotator #(
    .WIDTH (WIDTH)
  ) u_rotator (
    .data_i   (data_arr[gnt_idx]),
    .amount_i (amt_arr[gnt_idx]),
    .dir_i    (req_dir[gnt_idx]),
    .result_o (rot_result)
  );

  assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      if (accept) begin
        ptr_q <= ptr_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= rot_result;
            resp_id_q    <= gnt_idx;
          end
        end
        RESP: begin
          // Without resp_ready nothing changes: accept is forced low.
          if (resp_ready) begin
            if (accept) begin
              resp_data_q <= rot_result;
              resp_id_q   <= gnt_idx;
            end else begin
              state_q      <= IDLE;
              resp_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

`ifdef ROTATOR_ARB_STATS_EN
  logic [STATS_W-1:0] op_count_q;

  // Clear wins over a simultaneous handshake; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (stats_clr) begin
      op_count_q <= '0;
    end else if (resp_valid_q && resp_ready && (op_count_q != {STATS_W{1'b1}})) begin
      op_count_q <= op_count_q + 1'b1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_rotator_arbiter.sv
module tb_rotator_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int AMT_W   = 5;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ*AMT_W-1:0] req_amount;
  logic [NUM_REQ-1:0]       req_dir;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_data;
  logic [ID_W-1:0]          resp_id;
`ifdef ROTATOR_ARB_STATS_EN
  logic [15:0]              op_count;
  logic                     stats_clr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rotator_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amount (req_amount),
    .req_dir    (req_dir),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef ROTATOR_ARB_STATS_EN
    ,
    .op_count   (op_count),
    .stats_clr  (stats_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                         input logic dir);
    req_data[i*WIDTH +: WIDTH]   = d;
    req_amount[i*AMT_W +: AMT_W] = a;
    req_dir[i]                   = dir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_amount = '0;
    req_dir    = '0;
    resp_ready = 1'b0;
`ifdef ROTATOR_ARB_STATS_EN
    stats_clr  = 1'b0;
`endif

    // Reset: req_ready must stay low even with every valid raised.
    req_valid = 4'hF;
    #2;
    check("rst_ready", req_ready, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", resp_valid, 1'b0);
    check("rst_data", resp_data, 32'h0);
    check("rst_id", resp_id, 2'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Single request from requester 2: 0xF rotl 3.
    set_req(2, 32'h0000000F, 5'd3, 1'b0);
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    #1;
    check("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("t1_valid", resp_valid, 1'b1);
    check("t1_data", resp_data, 32'h00000078);
    check("t1_id", resp_id, 2'd2);
    tick();
    check("t1_drain", resp_valid, 1'b0);

    // Pointer is 3; requester 1 rotr 1 wraps the LSB to the MSB.
    set_req(1, 32'h80000001, 5'd1, 1'b1);
    req_valid = 4'b0010;
    #1;
    check("t2_ready", req_ready, 4'b0010);
    tick();
    check("t2_data", resp_data, 32'hC0000000);
    check("t2_id", resp_id, 2'd1);
    // Back-to-back with amount 0: data must come through unchanged.
    set_req(1, 32'h80000001, 5'd0, 1'b1);
    #1;
    check("t2_b2b_ready", req_ready, 4'b0010);
    tick();
    check("t2_amt0_valid", resp_valid, 1'b1);
    check("t2_amt0_data", resp_data, 32'h80000001);
    // Pointer is 2; requester 3 rotl 31 (maximum amount).
    set_req(3, 32'h00000001, 5'd31, 1'b0);
    req_valid = 4'b1000;
    #1;
    check("t2_max_ready", req_ready, 4'b1000);
    tick();
    check("t2_max_data", resp_data, 32'h80000000);
    check("t2_max_id", resp_id, 2'd3);
    req_valid = '0;
    tick();
    check("t2_drain", resp_valid, 1'b0);

    // Fairness: pointer is 0, all requesters valid, amount 0.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'hA0 + i, 5'd0, 1'b0);
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      check("rr_ready", req_ready, exp_g);
      tick();
      check("rr_valid", resp_valid, 1'b1);
      check("rr_id", resp_id, k % 4);
      check("rr_data", resp_data, 32'hA0 + (k % 4));
    end
    req_valid = '0;
    tick();
    check("rr_drain", resp_valid, 1'b0);

    // Backpressure: pointer is 2; result 0x0F00000F rotl 4 = 0xF00000F0.
    set_req(2, 32'h0F00000F, 5'd4, 1'b0);
    req_valid  = 4'b0100;
    resp_ready = 1'b0;
    #1;
    check("bp_ready", req_ready, 4'b0100);
    tick();
    check("bp_data", resp_data, 32'hF00000F0);
    set_req(3, 32'h12345678, 5'd8, 1'b1);
    set_req(0, 32'h12345678, 5'd16, 1'b0);
    req_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold_ready", req_ready, 4'b0000);
      tick();
      check("bp_hold_valid", resp_valid, 1'b1);
      check("bp_hold_data", resp_data, 32'hF00000F0);
      check("bp_hold_id", resp_id, 2'd2);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_rel_ready", req_ready, 4'b1000);
    tick();
    check("bp_rel_id", resp_id, 2'd3);
    check("bp_rel_data", resp_data, 32'h78123456);
    req_valid = 4'b0001;
    #1;
    check("bp_next_ready", req_ready, 4'b0001);
    tick();
    check("bp_next_id", resp_id, 2'd0);
    check("bp_next_data", resp_data, 32'h56781234);
    req_valid  = '0;
    resp_ready = 1'b0;
    tick();
    check("mid_held", resp_valid, 1'b1);

    // Reset mid-operation, between clock edges; pointer was 1 beforehand.
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", resp_valid, 1'b0);
    check("mid_rst_data", resp_data, 32'h0);
    #1;
    rst = 1'b0;
    set_req(0, 32'h00000001, 5'd1, 1'b0);
    set_req(1, 32'h00000004, 5'd1, 1'b0);
    req_valid  = 4'b0011;
    resp_ready = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    tick();
    check("post_rst_id", resp_id, 2'd0);
    check("post_rst_data", resp_data, 32'h00000002);
    req_valid = '0;
    tick();

`ifdef ROTATOR_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("st_clr0", op_count, 16'd0);
    set_req(0, 32'h1, 5'd0, 1'b0);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    repeat (10) tick();
    req_valid = '0;
    tick();
    check("st_count10", op_count, 16'd10);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("st_clr", op_count, 16'd0);
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = '0;
    tick();
    check("st_sat", op_count, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rotator_arbiter.md
Name: rotator_arbiter

Overview:
- Shares one combinational Rotator datapath among NUM_REQ independent requesters.
- Each requester uses its own valid/ready port; arbitration is round-robin.
- One operation is accepted per cycle. The result is registered and returned on a single valid/ready response port tagged with the requester ID.
- Sits between the ALU-side issue logic and the shared rotate resource.

Parameters:
- WIDTH, 32, data word width; the rotator width.
- NUM_REQ, 4, number of requesters (2..16).
- AMT_W, $clog2(WIDTH), rotate-amount width (derived, not overridable).
- ID_W, $clog2(NUM_REQ), response ID width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle (one-hot or zero).
- req_data  in  NUM_REQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_amount  in  NUM_REQ*AMT_W  rotate amounts, packed the same way.
- req_dir  in  NUM_REQ  0 = rotate left, 1 = rotate right.
- resp_valid  out  1  result valid.
- resp_ready  in  1  downstream accept.
- resp_data  out  WIDTH  rotated result.
- resp_id  out  ID_W  index of the requester that issued the result.

Behaviour:
- Reset values: resp_valid=0, resp_data=0, resp_id=0, round-robin pointer=0, state=IDLE.
  - req_ready is combinational and is 0 while rst is high.
- Acceptance: a transfer on requester i occurs when req_valid[i] && req_ready[i] at a rising edge.
- req_ready is granted only when the output slot is free:
  - slot_free = (state==IDLE) || (resp_valid && resp_ready).
  - Grant is one-hot to the first requester with valid set, searching upward from the pointer with wrap at NUM_REQ-1 -> 0.
  - req_ready never depends on req_valid of a non-winning requester.
- Datapath: the winner's operands are muxed into the Rotator; the output is registered into resp_data/resp_id on the accept edge. Latency: resp_valid rises one cycle after acceptance.
- Rotation semantics: a true circular rotate.
  - amount 0 -> data unchanged.
  - amount k -> bits move k positions circularly.
  - No bits are lost at any amount.
- Round-robin pointer: after a grant to index g, pointer <= (g+1) mod NUM_REQ. It is unchanged on cycles without a grant.
- FSM states:
  - IDLE: no result held. Grant -> RESP.
  - RESP: result held; resp_valid=1.
    - resp_ready && new grant -> stay in RESP and load the new result (back-to-back, full throughput).
    - resp_ready && no grant -> IDLE, resp_valid=0.
    - !resp_ready -> hold resp_data/resp_id stable, no grants.
- Backpressure: while resp_valid && !resp_ready, all req_ready bits are 0 and the output is held bit-stable.
- Simultaneous requests: exactly one winner per cycle. A losing requester holds valid and is served within NUM_REQ-1 subsequent grants (starvation-free).
- Request stability: requesters keep data/amount/dir stable until accepted. The block samples them only on the accept edge.
- Reset mid-operation: an asserted rst immediately clears resp_valid and the state. Held results are dropped and not replayed.

Optional Feature:
- Macro: ROTATOR_ARB_STATS_EN.
- Defined:
  - Adds output port op_count (16 bits): a count of completed response handshakes (resp_valid && resp_ready), saturating at 16'hFFFF.
  - Adds input port stats_clr (1 bit): synchronously zeroes the count. If stats_clr and a handshake occur in the same cycle, the result is 0.
  - The count resets to 0 on rst.
- Undefined: neither port exists, no counter logic is generated, and behaviour is otherwise identical.

Decomposition:
- Package rotator_pkg holds:
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
  - State enum arb_state_t {IDLE, RESP}.
  - The STATS_W=16 constant.
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register stays in the parent.
- The parent instantiates the existing Rotator, with WIDTH passed through.

Test Plan:
- Single request: requester 2 sends data=32'h0000000F, amount=3, dir=0.
  - Expect req_ready[2] on the first cycle.
  - Next cycle: resp_valid=1, resp_data=32'h00000078, resp_id=2.
- Wrap and amount 0:
  - data=32'h80000001, amount=1, dir=1 -> 32'hC0000000.
  - Same data, amount=0 -> 32'h80000001 (unchanged).
- Fairness: all 4 requesters hold valid continuously with resp_ready=1.
  - Grants rotate 0,1,2,3,0,... with one grant per cycle.
  - resp_id sequence matches, with no bubbles.
- Backpressure: hold resp_ready=0 for 5 cycles with result 32'hF00000F0 pending.
  - resp_data stays stable and req_ready=0 throughout.
  - On release, the next grant occurs in the same cycle as the handshake.
- Reset mid-operation: assert rst while in RESP with resp_ready=0.
  - resp_valid drops immediately (asynchronously).
  - After deassertion, the pointer is 0 and the first grant goes to the lowest valid index.
- With ROTATOR_ARB_STATS_EN:
  - 10 completed handshakes -> op_count=10.
  - Pulse stats_clr -> op_count=0.
  - Preload near saturation (force) -> op_count stays at 16'hFFFF.
